// File: rtl/led_blink_driver.sv
// Turns single-cycle event strobes into visible LED blinks (ON_CYCLES lit, OFF_CYCLES dark).
// Events that arrive during a blink are queued in a saturating pending counter.
module led_blink_driver #(
  parameter int unsigned ON_CYCLES   = 1000000,
  parameter int unsigned OFF_CYCLES  = 1000000,
  parameter int unsigned MAX_PENDING = 15,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 event_i,
  input  logic                                 clear_i,
  output logic                                 led_o,
  output logic                                 busy_o,
  output logic [$clog2(MAX_PENDING + 1) - 1:0] pending_o,
  output logic                                 overflow_o
);

  localparam int unsigned TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned PW   = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   pending_q, pending_d;
  logic            overflow_q, overflow_d;
  logic            led_q, led_d;
  logic            busy_q, busy_d;
  logic            start_c;

  // Next-state, timer, pending-counter and registered-output logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    start_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!clear_i && (pending_q != '0)) start_c = 1'b1;
      end
      ON: begin
        if (timer_q == '0) begin
          state_d = OFF;
          timer_d = TW'(OFF_CYCLES - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      OFF: begin
        if (timer_q == '0) begin
          if (!clear_i && (pending_q != '0)) start_c = 1'b1;
          else                               state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (start_c) begin
      state_d = ON;
      timer_d = TW'(ON_CYCLES - 1);
    end

    // A clear beats everything; an event that coincides with a start cancels out.
    if (clear_i) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end else if (event_i && start_c) begin
      pending_d = pending_q;
    end else if (event_i) begin
      if (pending_q < PW'(MAX_PENDING)) pending_d  = pending_q + PW'(1);
      else                              overflow_d = 1'b1;
    end else if (start_c) begin
      pending_d = pending_q - PW'(1);
    end

    led_d  = (state_d == ON) ^ ACTIVE_LOW;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      led_q      <= ACTIVE_LOW;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  assign led_o      = led_q;
  assign busy_o     = busy_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver: table vectors, directed corner sequences and random
// stimulus checked against a blink-phase reference model.
module tb_led_blink_driver;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int MAXP = 3;
  localparam int PER = ON + OFF;

  logic       clk = 1'b0;
  logic       rst_n, ev, clr;
  logic       led, busy, ovf;
  logic       led_al, busy_al, ovf_al;
  logic [1:0] pend, pend_al;

  always #5 clk = ~clk;

  led_blink_driver #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_PENDING(MAXP), .ACTIVE_LOW(1'b0)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .event_i(ev), .clear_i(clr),
    .led_o(led), .busy_o(busy), .pending_o(pend), .overflow_o(ovf)
  );

  led_blink_driver #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_PENDING(MAXP), .ACTIVE_LOW(1'b1)) dut_al (
    .clk_i(clk), .reset_n_i(rst_n), .event_i(ev), .clear_i(clr),
    .led_o(led_al), .busy_o(busy_al), .pending_o(pend_al), .overflow_o(ovf_al)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a blink is a window of PER cycles; phase counts cycles into it.
  bit m_active;
  int m_phase;
  int m_pend;
  bit m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit e, input bit c, input bit r);
    bit can_start;
    if (!r) begin
      m_active = 0; m_phase = 0; m_pend = 0; m_ovf = 0;
      return;
    end
    can_start = (!m_active || m_phase == PER - 1) && (m_pend > 0) && !c;
    if (can_start) begin
      m_active = 1; m_phase = 0;
    end else if (m_active) begin
      if (m_phase == PER - 1) m_active = 0;
      else                    m_phase++;
    end
    if (c) begin
      m_pend = 0; m_ovf = 0;
    end else if (e && can_start) begin
      m_pend = m_pend;
    end else if (e) begin
      if (m_pend < MAXP) m_pend++;
      else               m_ovf = 1;
    end else if (can_start) begin
      m_pend--;
    end
  endtask

  task automatic step(input bit e, input bit c, input bit r);
    bit m_led;
    @(negedge clk);
    ev = e; clr = c; rst_n = r;
    @(posedge clk);
    model_edge(e, c, r);
    #1;
    m_led = m_active && (m_phase < ON);
    chk("model_led", int'(led), int'(m_led));
    chk("model_led_al", int'(led_al), int'(!m_led));
    chk("model_busy", int'(busy), int'(m_active));
    chk("model_pending", int'(pend), m_pend);
    chk("model_overflow", int'(ovf), int'(m_ovf));
  endtask

  typedef struct {
    bit e; bit c; bit r;
    bit led; bit busy; int pend; bit ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit e, input bit c, input bit r,
                              input bit l, input bit b, input int p, input bit o);
    vec_t v;
    v.e = e; v.c = c; v.r = r; v.led = l; v.busy = b; v.pend = p; v.ovf = o;
    vecs.push_back(v);
  endfunction

  initial begin
    int exp5[5];
    int blinks, on_cnt, busy_cnt;
    bit prev;
    exp5[0] = 1; exp5[1] = 1; exp5[2] = 2; exp5[3] = 3; exp5[4] = 3;
    ev = 0; clr = 0; rst_n = 0;

    // Single pulse then two back-to-back pulses, starting from reset.
    add(0,0,0, 0,0,0,0);
    add(1,0,1, 0,0,1,0);
    add(0,0,1, 1,1,0,0); add(0,0,1, 1,1,0,0); add(0,0,1, 1,1,0,0);
    add(0,0,1, 0,1,0,0); add(0,0,1, 0,1,0,0); add(0,0,1, 0,0,0,0);
    add(1,0,1, 0,0,1,0); add(1,0,1, 1,1,1,0);
    add(0,0,1, 1,1,1,0); add(0,0,1, 1,1,1,0); add(0,0,1, 0,1,1,0); add(0,0,1, 0,1,1,0);
    add(0,0,1, 1,1,0,0); add(0,0,1, 1,1,0,0); add(0,0,1, 1,1,0,0);
    add(0,0,1, 0,1,0,0); add(0,0,1, 0,1,0,0); add(0,0,1, 0,0,0,0);

    step(0, 0, 0);
    chk("reset_led_al", int'(led_al), 1);
    foreach (vecs[i]) begin
      step(vecs[i].e, vecs[i].c, vecs[i].r);
      chk($sformatf("vec%0d_led", i), int'(led), int'(vecs[i].led));
      chk($sformatf("vec%0d_led_al", i), int'(led_al), int'(!vecs[i].led));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d_pending", i), int'(pend), vecs[i].pend);
      chk($sformatf("vec%0d_overflow", i), int'(ovf), int'(vecs[i].ovf));
    end

    // Five consecutive events saturate the queue: four blinks, sticky overflow.
    step(0, 0, 0);
    blinks = 0; prev = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1);
      chk("sat_pending", int'(pend), exp5[i]);
      chk("sat_overflow", int'(ovf), (i == 4) ? 1 : 0);
      if (led && !prev) blinks++;
      prev = led;
    end
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1);
      if (led && !prev) blinks++;
      prev = led;
    end
    chk("sat_blinks", blinks, 4);
    chk("sat_overflow_sticky", int'(ovf), 1);
    chk("sat_idle", int'(busy), 0);

    // Clear during the first ON: current blink completes, nothing follows.
    step(0, 0, 0);
    on_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1);
      on_cnt += int'(led); busy_cnt += int'(busy);
    end
    step(0, 1, 1);
    on_cnt += int'(led); busy_cnt += int'(busy);
    chk("clr_pending", int'(pend), 0);
    chk("clr_overflow", int'(ovf), 0);
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 1);
      on_cnt += int'(led); busy_cnt += int'(busy);
    end
    chk("clr_on_cycles", on_cnt, ON);
    chk("clr_busy_cycles", busy_cnt, PER);

    // Event and clear together while idle with work pending: nothing starts.
    step(0, 0, 0);
    step(1, 0, 1);
    step(1, 1, 1);
    chk("evclr_pending", int'(pend), 0);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1);
      busy_cnt += int'(busy);
    end
    chk("evclr_busy_cycles", busy_cnt, 0);

    // Reset in the middle of ON with two queued blinks.
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    chk("midon_led", int'(led), 1);
    chk("midon_pending", int'(pend), 2);
    step(0, 0, 0);
    chk("rst_led", int'(led), 0);
    chk("rst_led_al", int'(led_al), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pend), 0);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1);
      busy_cnt += int'(busy);
    end
    chk("rst_busy_cycles", busy_cnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 3, $urandom_range(0, 199) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
